mips_stage_sequencer: RTL and testbench



---
 rtl/mips_stage_sequencer.sv | 120 ++++++++++++
 tb/tb_mips_stage_sequencer.sv | 245 ++++++++++++++++++++++++
 2 files changed

// File: rtl/mips_stage_sequencer.sv
// Multicycle control sequencer: FETCH, 1..MAX_EXEC execute stages, HALT.
// Define MIPS_STAGE_SEQUENCER_STALL_CNT_EN to add the stall_cycles counter.
module mips_stage_sequencer #(
   parameter  int MAX_EXEC = 4,
   parameter  int CNT_W    = 32,
   localparam int LEN_W    = $clog2(MAX_EXEC + 1),
   localparam int STATE_W  = $clog2(MAX_EXEC + 2)
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               halt,
   input  logic [LEN_W-1:0]   exec_len,
   input  logic               waitrequest,
   output logic [STATE_W-1:0] state,
   output logic               is_fetch,
   output logic               is_halt,
   output logic               instr_done,
   output logic [CNT_W-1:0]   retired
`ifdef MIPS_STAGE_SEQUENCER_STALL_CNT_EN
   ,
   output logic [CNT_W-1:0]   stall_cycles
`endif
);

   typedef enum logic [STATE_W-1:0] {
      S_FETCH = '0,
      S_EXEC1 = STATE_W'(1),
      S_HALT  = '1
   } state_e;

   state_e             state_q, state_d;
   logic [LEN_W-1:0]   len_q, len_d;
   logic               done_q, done_d;
   logic [CNT_W-1:0]   ret_q, ret_d;
   logic [LEN_W-1:0]   len_clamp;
   logic [LEN_W-1:0]   eff_len;

   always_comb begin
      len_clamp = exec_len;
      if (exec_len <= LEN_W'(1)) begin
         len_clamp = LEN_W'(1);
      end else if (exec_len > LEN_W'(MAX_EXEC)) begin
         len_clamp = LEN_W'(MAX_EXEC);
      end
   end

   // EXEC1 uses the live decoder length; later stages use the captured one
   assign eff_len = (state_q == S_EXEC1) ? len_clamp : len_q;

   always_comb begin
      state_d = state_q;
      len_d   = len_q;
      done_d  = 1'b0;
      ret_d   = ret_q;
      if (state_q == S_HALT) begin
         state_d = S_HALT;
      end else if (waitrequest) begin
         state_d = state_q;
      end else if (halt) begin
         state_d = S_HALT;
      end else if (state_q == S_FETCH) begin
         state_d = S_EXEC1;
      end else if (state_q <= STATE_W'(MAX_EXEC)) begin
         if (state_q == S_EXEC1) begin
            len_d = len_clamp;
         end
         if (state_q < STATE_W'(eff_len)) begin
            state_d = state_e'(state_q + STATE_W'(1));
         end else begin
            state_d = S_FETCH;
            done_d  = 1'b1;
            ret_d   = ret_q + CNT_W'(1);
         end
      end else begin
         state_d = S_FETCH;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= S_FETCH;
         len_q   <= '0;
         done_q  <= 1'b0;
         ret_q   <= '0;
      end else begin
         state_q <= state_d;
         len_q   <= len_d;
         done_q  <= done_d;
         ret_q   <= ret_d;
      end
   end

`ifdef MIPS_STAGE_SEQUENCER_STALL_CNT_EN
   logic [CNT_W-1:0] stall_q, stall_d;

   always_comb begin
      stall_d = stall_q;
      if (state_q != S_HALT && waitrequest) begin
         stall_d = stall_q + CNT_W'(1);
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         stall_q <= '0;
      end else begin
         stall_q <= stall_d;
      end
   end

   assign stall_cycles = stall_q;
`endif

   assign state      = state_q;
   assign is_fetch   = (state_q == S_FETCH);
   assign is_halt    = (state_q == S_HALT);
   assign instr_done = done_q;
   assign retired    = ret_q;

endmodule

// File: tb/tb_mips_stage_sequencer.sv
// Bench for mips_stage_sequencer: behavioural model compared every cycle,
// directed scenarios with literal expectations, then randomized traffic.
module tb_mips_stage_sequencer;

   localparam int MAX_EXEC = 4;
   localparam int CNT_W    = 4;
   localparam int MODV     = 1 << CNT_W;
   localparam int HALT_V   = 7;

   logic       clk = 1'b0;
   logic       rst_n;
   logic       halt;
   logic [2:0] exec_len;
   logic       waitrequest;
   logic [2:0] state;
   logic       is_fetch;
   logic       is_halt;
   logic       instr_done;
   logic [CNT_W-1:0] retired;
`ifdef MIPS_STAGE_SEQUENCER_STALL_CNT_EN
   logic [CNT_W-1:0] stall_cycles;
`endif

   int checks = 0;
   int errors = 0;

   mips_stage_sequencer #(
      .MAX_EXEC(MAX_EXEC),
      .CNT_W(CNT_W)
   ) dut (
      .clk(clk),
      .rst_n(rst_n),
      .halt(halt),
      .exec_len(exec_len),
      .waitrequest(waitrequest),
      .state(state),
      .is_fetch(is_fetch),
      .is_halt(is_halt),
      .instr_done(instr_done),
      .retired(retired)
`ifdef MIPS_STAGE_SEQUENCER_STALL_CNT_EN
      ,
      .stall_cycles(stall_cycles)
`endif
   );

   always #5 clk = ~clk;

   // Reference: stage number, instruction length, counters as plain ints
   int m_state, m_len, m_done, m_ret, m_stall;

   function automatic int clampf(input int l);
      if (l <= 1) return 1;
      if (l > MAX_EXEC) return MAX_EXEC;
      return l;
   endfunction

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         m_state <= 0;
         m_len   <= 0;
         m_done  <= 0;
         m_ret   <= 0;
         m_stall <= 0;
      end else begin
         m_done <= 0;
         if (m_state != HALT_V) begin
            if (waitrequest) begin
               m_stall <= (m_stall + 1) % MODV;
            end else if (halt) begin
               m_state <= HALT_V;
            end else if (m_state == 0) begin
               m_state <= 1;
            end else if (m_state > MAX_EXEC) begin
               m_state <= 0;
            end else begin
               if (m_state == 1) m_len <= clampf(int'(exec_len));
               if (m_state < ((m_state == 1) ? clampf(int'(exec_len)) : m_len)) begin
                  m_state <= m_state + 1;
               end else begin
                  m_state <= 0;
                  m_done  <= 1;
                  m_ret   <= (m_ret + 1) % MODV;
               end
            end
         end
      end
   end

   task automatic chk(input string nm, input longint act, input longint exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
      end
   endtask

   always @(negedge clk) begin
      chk("state", longint'(state), longint'(m_state));
      chk("is_fetch", longint'(is_fetch), longint'(m_state == 0));
      chk("is_halt", longint'(is_halt), longint'(m_state == HALT_V));
      chk("instr_done", longint'(instr_done), longint'(m_done));
      chk("retired", longint'(retired), longint'(m_ret));
`ifdef MIPS_STAGE_SEQUENCER_STALL_CNT_EN
      chk("stall_cycles", longint'(stall_cycles), longint'(m_stall));
`endif
   end

   task automatic tick(input logic h, input logic w, input int l);
      halt        = h;
      waitrequest = w;
      exec_len    = 3'(l);
      @(posedge clk);
      #2;
   endtask

   task automatic do_reset();
      rst_n = 1'b0;
      @(posedge clk);
      #2;
      rst_n = 1'b1;
   endtask

   task automatic run_instr(input int l, output int cyc);
      cyc = 0;
      do begin
         tick(1'b0, 1'b0, l);
         cyc++;
      end while (!instr_done && cyc < 20);
   endtask

   initial begin
      #400000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "timeout");
   end

   initial begin
      int cyc, dn, r0;
      int lens[4] = '{1, 3, 0, 7};
      int cyc_exp[4] = '{2, 4, 2, 5};
      rst_n = 1'b0;
      halt = 1'b0;
      waitrequest = 1'b0;
      exec_len = 3'd0;
      #1;
      chk("reset state", longint'(state), 0);
      chk("reset is_fetch", longint'(is_fetch), 1);
      do_reset();

      // Lengths and clamping
      for (int i = 0; i < 4; i++) begin
         run_instr(lens[i], cyc);
         chk("instr cycles", cyc, cyc_exp[i]);
      end
      chk("retired after 4", longint'(retired), 4);

      // Async reset mid-EXEC3
      tick(1'b0, 1'b0, 4);
      tick(1'b0, 1'b0, 4);
      tick(1'b0, 1'b0, 4);
      chk("in EXEC3", longint'(state), 3);
      rst_n = 1'b0;
      #1;
      chk("async rst state", longint'(state), 0);
      chk("async rst retired", longint'(retired), 0);
      chk("async rst done", longint'(instr_done), 0);
      @(posedge clk);
      #2;
      rst_n = 1'b1;
      tick(1'b0, 1'b0, 4);
      chk("after rst EXEC1", longint'(state), 1);
      do_reset();

      // Stall sequence 0,1,1,1,2,2,2,2,0
      dn = 0;
      tick(1'b0, 1'b0, 2); chk("stall s1", longint'(state), 1);
      tick(1'b0, 1'b1, 2); dn += int'(instr_done);
      tick(1'b0, 1'b1, 2); chk("stall s1 hold", longint'(state), 1);
      dn += int'(instr_done);
      tick(1'b0, 1'b0, 2); chk("stall s2", longint'(state), 2);
      for (int i = 0; i < 3; i++) begin
         tick(1'b0, 1'b1, 0);
         dn += int'(instr_done);
      end
      chk("stall s2 hold", longint'(state), 2);
      tick(1'b0, 1'b0, 0); dn += int'(instr_done);
      chk("stall end", longint'(state), 0);
      chk("stall done count", dn, 1);
`ifdef MIPS_STAGE_SEQUENCER_STALL_CNT_EN
      chk("stall_cycles", longint'(stall_cycles), 5);
`endif

      // Halt from FETCH, absorbing, reset exit
      tick(1'b1, 1'b0, 0); chk("halt enter", longint'(state), HALT_V);
      tick(1'b0, 1'b0, 0); chk("halt stay", longint'(state), HALT_V);
      tick(1'b1, 1'b1, 0); chk("halt stay w", longint'(state), HALT_V);
      do_reset();
      chk("halt exit", longint'(state), 0);

      // Halt in EXEC2 abandons the instruction
      run_instr(1, cyc);
      r0 = int'(retired);
      tick(1'b0, 1'b0, 4);
      tick(1'b0, 1'b0, 4);
      chk("pre-halt EXEC2", longint'(state), 2);
      tick(1'b1, 1'b0, 4);
      chk("halt EXEC2", longint'(state), HALT_V);
      chk("halt no retire", longint'(retired), r0);
      chk("halt no done", longint'(instr_done), 0);
      do_reset();

      // Halt under stall
      tick(1'b0, 1'b0, 2);
      tick(1'b1, 1'b1, 2); chk("halt+wait hold", longint'(state), 1);
      tick(1'b1, 1'b0, 2); chk("halt after wait", longint'(state), HALT_V);
      do_reset();

      // Retire counter wrap
      for (int i = 1; i <= 17; i++) begin
         run_instr(1, cyc);
         if (i == 15) chk("wrap 15", longint'(retired), 15);
         if (i == 16) chk("wrap 16", longint'(retired), 0);
         if (i == 17) chk("wrap 17", longint'(retired), 1);
      end

      // Randomized traffic
      for (int i = 0; i < 3000; i++) begin
         if ((m_state == HALT_V && $urandom_range(3) == 0) ||
             $urandom_range(299) == 0) begin
            do_reset();
         end else begin
            tick(1'($urandom_range(40) == 0),
                 1'($urandom_range(3) == 0),
                 int'($urandom_range(7)));
         end
      end

      @(negedge clk);
      #1;
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
